// File: rtl/dsp_ctrl_pipe.sv
// Parametrised control-word pipeline for the DSP slice: configurable width/depth,
// per-stage valid, synchronous flush, and change/stability status.
module dsp_ctrl_pipe #(
  parameter int unsigned      WIDTH   = 3,
  parameter int unsigned      DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             CLK,
  input  logic             RSTCTRL,
  input  logic             CECTRL,
  input  logic             FLUSH,
  input  logic [WIDTH-1:0] CTRL_IN,
  input  logic             VALID_IN,
  output logic [WIDTH-1:0] CTRL_OUT,
  output logic             VALID_OUT,
  output logic             CHANGED,
  output logic             STABLE
);

  if (WIDTH == 0 || WIDTH > 32 || DEPTH > 4) begin : g_param_err
    $error("dsp_ctrl_pipe: WIDTH must be 1..32 and DEPTH 0..4");
  end

  if (DEPTH == 0) begin : g_bypass
    logic w_unused;
    assign w_unused  = &{1'b0, CLK, RSTCTRL, CECTRL, FLUSH};
    assign CTRL_OUT  = CTRL_IN;
    assign VALID_OUT = VALID_IN;
    assign STABLE    = VALID_IN;
    assign CHANGED   = 1'b0;
  end else begin : g_pipe
    logic [DEPTH-1:0][WIDTH-1:0] r_stage;
    logic [DEPTH-1:0]            r_vld;
    logic                        r_changed;
    logic [DEPTH-1:0][WIDTH-1:0] w_next_stage;
    logic [DEPTH-1:0]            w_next_vld;
    logic                        w_changed;
    logic                        w_stable;

    // Shifted contents if this edge is enabled; invalid words shift too.
    always_comb begin
      w_next_stage    = r_stage;
      w_next_vld      = r_vld;
      w_next_stage[0] = CTRL_IN;
      w_next_vld[0]   = VALID_IN;
      for (int i = 1; i < int'(DEPTH); i++) begin
        w_next_stage[i] = r_stage[i-1];
        w_next_vld[i]   = r_vld[i-1];
      end
      w_changed = r_vld[DEPTH-1] & w_next_vld[DEPTH-1] &
                  (w_next_stage[DEPTH-1] != r_stage[DEPTH-1]);
    end

    always_ff @(posedge CLK or posedge RSTCTRL) begin
      if (RSTCTRL) begin
        r_stage   <= {DEPTH{RST_VAL}};
        r_vld     <= '0;
        r_changed <= 1'b0;
      end else if (FLUSH) begin
        r_stage   <= {DEPTH{RST_VAL}};
        r_vld     <= '0;
        r_changed <= 1'b0;
      end else if (CECTRL) begin
        r_stage   <= w_next_stage;
        r_vld     <= w_next_vld;
        r_changed <= w_changed;
      end else begin
        r_changed <= 1'b0;
      end
    end

    // All stages valid and holding the same word.
    always_comb begin
      w_stable = &r_vld;
      for (int i = 1; i < int'(DEPTH); i++) begin
        if (r_stage[i] != r_stage[0]) w_stable = 1'b0;
      end
    end

    assign CTRL_OUT  = r_stage[DEPTH-1];
    assign VALID_OUT = r_vld[DEPTH-1];
    assign CHANGED   = r_changed;
    assign STABLE    = w_stable;
  end

endmodule

// File: tb/tb_dsp_ctrl_pipe.sv
// Directed bench for dsp_ctrl_pipe: four instances (DEPTH 0..3) on shared stimulus.
module tb_dsp_ctrl_pipe;

  logic       clk = 1'b0;
  logic       rst, ce, flush, vin;
  logic [2:0] cin;

  logic [2:0] o0, o1, o2, o3;
  logic       v0, v1, v2, v3;
  logic       c0, c1, c2, c3;
  logic       s0, s1, s2, s3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dsp_ctrl_pipe #(.WIDTH(3), .DEPTH(0), .RST_VAL(3'b000)) u_d0 (
    .CLK(clk), .RSTCTRL(rst), .CECTRL(ce), .FLUSH(flush), .CTRL_IN(cin), .VALID_IN(vin),
    .CTRL_OUT(o0), .VALID_OUT(v0), .CHANGED(c0), .STABLE(s0));
  dsp_ctrl_pipe #(.WIDTH(3), .DEPTH(1), .RST_VAL(3'b000)) u_d1 (
    .CLK(clk), .RSTCTRL(rst), .CECTRL(ce), .FLUSH(flush), .CTRL_IN(cin), .VALID_IN(vin),
    .CTRL_OUT(o1), .VALID_OUT(v1), .CHANGED(c1), .STABLE(s1));
  dsp_ctrl_pipe #(.WIDTH(3), .DEPTH(2), .RST_VAL(3'b101)) u_d2 (
    .CLK(clk), .RSTCTRL(rst), .CECTRL(ce), .FLUSH(flush), .CTRL_IN(cin), .VALID_IN(vin),
    .CTRL_OUT(o2), .VALID_OUT(v2), .CHANGED(c2), .STABLE(s2));
  dsp_ctrl_pipe #(.WIDTH(3), .DEPTH(3), .RST_VAL(3'b000)) u_d3 (
    .CLK(clk), .RSTCTRL(rst), .CECTRL(ce), .FLUSH(flush), .CTRL_IN(cin), .VALID_IN(vin),
    .CTRL_OUT(o3), .VALID_OUT(v3), .CHANGED(c3), .STABLE(s3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({o2, v2, c2, s2} !== {3'b101, 1'b0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_init got %b exp %b", {o2, v2, c2, s2}, 6'b101000);
    end
    ce = 1'b1; cin = 3'b010; vin = 1'b1;
    tick(); tick();
    checks++;
    if ({o2, v2, s2} !== {3'b010, 1'b1, 1'b1}) begin
      errors++; $display("FAIL reset_fill got %b exp %b", {o2, v2, s2}, 5'b01011);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({o2, v2, c2, s2} !== {3'b101, 1'b0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_async got %b exp %b", {o2, v2, c2, s2}, 6'b101000);
    end
    #1 rst = 1'b0;
    tick(); tick();
    checks++;
    if ({o2, v2, s2} !== {3'b010, 1'b1, 1'b1}) begin
      errors++; $display("FAIL reset_refill got %b exp %b", {o2, v2, s2}, 5'b01011);
    end
    ce = 1'b0;
    do_flush();
    checks++;
    if ({o2, v2, c2, s2} !== {3'b101, 1'b0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL flush_state got %b exp %b", {o2, v2, c2, s2}, 6'b101000);
    end
  endtask

  task automatic test_latency();
    do_flush();
    ce = 1'b1; cin = 3'b010; vin = 1'b1;
    tick();
    cin = 3'b000; vin = 1'b0; ce = 1'b0;
    tick(); tick();
    checks++;
    if (v3 !== 1'b0) begin
      errors++; $display("FAIL lat_stall got %b exp 0", v3);
    end
    ce = 1'b1;
    tick();
    checks++;
    if (v3 !== 1'b0) begin
      errors++; $display("FAIL lat_edge4 got %b exp 0", v3);
    end
    tick();
    checks++;
    if ({o3, v3} !== {3'b010, 1'b1}) begin
      errors++; $display("FAIL lat_edge5 got %b exp %b", {o3, v3}, 4'b0101);
    end
    tick();
    checks++;
    if ({o3, v3} !== {3'b000, 1'b0}) begin
      errors++; $display("FAIL lat_edge6 got %b exp %b", {o3, v3}, 4'b0000);
    end
  endtask

  task automatic test_changed();
    logic [2:0] words [5] = '{3'b001, 3'b001, 3'b110, 3'b110, 3'b011};
    logic       exp_c [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    do_flush();
    ce = 1'b1; vin = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cin = words[i];
      tick();
      checks++;
      if ({o1, v1, c1} !== {words[i], 1'b1, exp_c[i]}) begin
        errors++;
        $display("FAIL changed_%0d got %b exp %b", i, {o1, v1, c1}, {words[i], 1'b1, exp_c[i]});
      end
    end
    ce = 1'b0; cin = 3'b100;
    tick();
    checks++;
    if ({o1, v1, c1} !== {3'b011, 1'b1, 1'b0}) begin
      errors++; $display("FAIL changed_hold got %b exp %b", {o1, v1, c1}, 5'b01110);
    end
  endtask

  task automatic test_stable();
    logic exp_s [3] = '{1'b0, 1'b0, 1'b1};
    do_flush();
    ce = 1'b1; cin = 3'b111; vin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (s3 !== exp_s[i]) begin
        errors++; $display("FAIL stable_edge%0d got %b exp %b", i + 1, s3, exp_s[i]);
      end
    end
    cin = 3'b000;
    tick();
    checks++;
    if (s3 !== 1'b0) begin
      errors++; $display("FAIL stable_fall got %b exp 0", s3);
    end
  endtask

  task automatic test_flush_vs_ce();
    do_flush();
    ce = 1'b1; vin = 1'b1; cin = 3'b110;
    tick(); tick();
    cin = 3'b001;
    tick(); tick();
    checks++;
    if ({o2, v2, c2} !== {3'b001, 1'b1, 1'b1}) begin
      errors++; $display("FAIL flush_pre got %b exp %b", {o2, v2, c2}, 5'b00111);
    end
    ce = 1'b0; cin = 3'b011; vin = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if ({o2, v2, c2, s2} !== {3'b101, 1'b0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL flush_edge got %b exp %b", {o2, v2, c2, s2}, 6'b101000);
    end
    ce = 1'b1; cin = 3'b000; vin = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (v2 !== 1'b0) begin
        errors++; $display("FAIL flush_drop%0d got %b exp 0", i, v2);
      end
    end
  endtask

  task automatic test_bypass();
    logic [2:0] words [4] = '{3'b000, 3'b111, 3'b010, 3'b101};
    logic       vals  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    ce = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rst = (i >= 2);
      cin = words[i]; vin = vals[i];
      #1;
      checks++;
      if ({o0, v0, s0, c0} !== {words[i], vals[i], vals[i], 1'b0}) begin
        errors++;
        $display("FAIL bypass_%0d got %b exp %b", i, {o0, v0, s0, c0}, {words[i], vals[i], vals[i], 1'b0});
      end
      tick();
      checks++;
      if (c0 !== 1'b0) begin
        errors++; $display("FAIL bypass_chg%0d got %b exp 0", i, c0);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; flush = 1'b0; vin = 1'b0; cin = 3'b000;
    #12 rst = 1'b0;
    tick();
    test_reset();
    test_latency();
    test_changed();
    test_stable();
    test_flush_vs_ce();
    test_bypass();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
